// File: rtl/regfile_pkg.sv
// Types and sizes shared by the register file, the core and the debug dump engine.
package regfile_pkg;

  localparam int NREGS_DEFAULT = 32;
  localparam int RF_AW         = 5;
  localparam int RF_DW         = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    READ,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dumper.sv
// Debug read-out engine: halts the CPU, then streams x0..x(NREGS-1) from one
// register-file read port over a valid/ready link, tagged with the index.
module regfile_dumper
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [AW-1:0]     rf_address,
  input  logic [DW-1:0]     rf_rs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [AW-1:0]     out_index,
  output logic              out_last,
  output dump_state_t       dbg_state
);

  // Handshake: a beat transfers on any rising edge where out_valid && out_ready;
  // once raised, out_valid and the beat fields hold until that transfer.

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  dump_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] index_q, index_d;
  logic          last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (halt_ack) state_d = READ;
      end
      READ: begin
        // Only capture while the core still guarantees the read port is ours.
        if (halt_ack) begin
          data_d  = rf_rs;
          index_d = idx_q;
          last_d  = (idx_q == LAST_IDX);
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign halt_req   = (state_q == WAIT_ACK) || (state_q == READ) || (state_q == SEND);
  assign rf_address = (state_q == IDLE) ? '0 : idx_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_index  = index_q;
  assign out_last   = last_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper with a behavioural register file and a
// beat scoreboard built from the values the bench wrote.
module tb_regfile_dumper;
  import regfile_pkg::*;

  localparam int NR = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              halt_req;
  logic              halt_ack;
  logic [4:0]        rf_address;
  logic [31:0]       rf_rs;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [4:0]        out_index;
  logic              out_last;
  dump_state_t       dbg_state;

  // register file: write port driven by the bench, x0 hardwired to zero
  logic              we;
  logic [4:0]        address3;
  logic [31:0]       wr;
  logic [31:0]       rf_mem [NR];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int beats_total = 0;

  logic [31:0] model_rf [NR];
  logic [37:0] exp_q [$];

  always #5 clk = ~clk;

  regfile_dumper #(.NREGS(NR), .AW(5), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .halt_req   (halt_req),
    .halt_ack   (halt_ack),
    .rf_address (rf_address),
    .rf_rs      (rf_rs),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .dbg_state  (dbg_state)
  );

  always @(posedge clk) begin
    if (we && address3 != 5'd0) rf_mem[address3] <= wr;
  end
  assign rf_rs = (rf_address == 5'd0) ? 32'd0 : rf_mem[rf_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    for (int i = 0; i < NR; i++) exp_q.push_back({(i == NR - 1), 5'(i), model_rf[i]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_beat(input logic [4:0] idx);
    int c;
    c = 0;
    while (!(out_valid && out_index == idx) && c < 200) begin
      tick();
      c++;
    end
    if (c >= 200) check("wait_beat_timeout", 32'(c), 32'd0);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 300) begin
      tick();
      cycles++;
    end
    if (!done) check("wait_done_timeout", 32'(cycles), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_halt_req"}, 32'(halt_req), 32'd0);
    check({tag, "_rf_address"}, 32'(rf_address), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_index"}, 32'(out_index), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
  endtask

  // compare process: every accepted beat against the scoreboard, held beats for stability
  logic        stall_q = 1'b0;
  logic [37:0] held_q;
  always @(negedge clk) begin
    logic [37:0] e;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_beat", {26'd0, out_last, out_index}, {26'd0, held_q[37:32]});
        check("hold_data", out_data, held_q[31:0]);
      end
      if (out_valid && out_ready) begin
        beats_total++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(out_index), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_index", 32'(out_index), 32'(e[36:32]));
          check("beat_data", out_data, e[31:0]);
          check("beat_last", 32'(out_last), 32'(e[37]));
          if (out_index == 5'd3)  check("pin_x3", out_data, 32'h03030303);
          if (out_index == 5'd31) check("pin_x31", out_data, 32'h1F1F1F1F);
          if (out_index == 5'd0)  check("pin_x0", out_data, 32'h00000000);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_queue_empty", 32'(exp_q.size()), 32'd0);
      end
      stall_q = out_valid && !out_ready;
      held_q  = {out_last, out_index, out_data};
    end
  end

  initial begin
    int cyc;
    int d0;
    int b0;
    rst = 1'b1; start = 1'b0; halt_ack = 1'b0; out_ready = 1'b0;
    we = 1'b0; address3 = '0; wr = '0;
    for (int i = 0; i < NR; i++) rf_mem[i] = 32'd0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // preload x1..x31
    model_rf[0] = 32'd0;
    for (int i = 1; i < NR; i++) begin
      we = 1'b1; address3 = 5'(i); wr = i * 32'h01010101;
      model_rf[i] = i * 32'h01010101;
      tick();
    end
    we = 1'b0;
    tick();

    // full dump with no stall: fixed cycle count to done
    halt_ack = 1'b1; out_ready = 1'b1;
    d0 = done_cnt; b0 = beats_total;
    push_dump();
    pulse_start();
    check("t1_halt_req_after_E0", 32'(halt_req), 32'd1);
    check("t1_busy_after_E0", 32'(busy), 32'd1);
    tick();
    check("t1_valid_after_E1", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid_after_E2", 32'(out_valid), 32'd1);
    check("t1_first_index", 32'(out_index), 32'd0);
    wait_done(cyc);
    check("t1_done_cycle", 32'(cyc + 2), 32'd65);
    tick();
    check("t1_done_one_cycle", 32'(done), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_halt_req_after", 32'(halt_req), 32'd0);
    tick(2);
    check("t1_beats", 32'(beats_total - b0), 32'd32);
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // backpressure on beat 3
    d0 = done_cnt; b0 = beats_total;
    push_dump();
    pulse_start();
    wait_beat(5'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_stall_valid", 32'(out_valid), 32'd1);
      check("t2_stall_index", 32'(out_index), 32'd3);
      check("t2_stall_data", out_data, 32'h03030303);
    end
    out_ready = 1'b1;
    wait_done(cyc);
    tick(3);
    check("t2_beats", 32'(beats_total - b0), 32'd32);
    check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

    // delayed grant
    halt_ack = 1'b0;
    d0 = done_cnt;
    push_dump();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("t3_halt_req_wait", 32'(halt_req), 32'd1);
      check("t3_valid_wait", 32'(out_valid), 32'd0);
      if (i < 3) tick();
    end
    halt_ack = 1'b1;
    tick();
    check("t3_valid_ack_plus1", 32'(out_valid), 32'd0);
    check("t3_halt_req_ack_plus1", 32'(halt_req), 32'd1);
    tick();
    check("t3_valid_ack_plus2", 32'(out_valid), 32'd1);
    wait_done(cyc);
    tick(3);
    check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);

    // grant loss while reading x7
    d0 = done_cnt;
    push_dump();
    pulse_start();
    cyc = 0;
    while (!(busy && !out_valid && rf_address == 5'd7) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("t4_reach_read7", 32'(cyc < 200), 32'd1);
    halt_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_capture", 32'(out_valid), 32'd0);
      check("t4_halt_req", 32'(halt_req), 32'd1);
    end
    halt_ack = 1'b1;
    tick();
    check("t4_beat7_valid", 32'(out_valid), 32'd1);
    check("t4_beat7_index", 32'(out_index), 32'd7);
    check("t4_beat7_data", out_data, 32'h07070707);
    wait_done(cyc);
    tick(3);
    check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

    // start while busy is ignored
    d0 = done_cnt; b0 = beats_total;
    push_dump();
    pulse_start();
    wait_beat(5'd10);
    pulse_start();
    wait_done(cyc);
    tick(6);
    check("t5_beats", 32'(beats_total - b0), 32'd32);
    check("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t5_idle", 32'(busy), 32'd0);

    // reset mid-dump, then a clean dump from index 0
    d0 = done_cnt;
    push_dump();
    pulse_start();
    wait_beat(5'd10);
    rst = 1'b1;
    tick();
    check_reset_outputs("t6_rst");
    rst = 1'b0;
    exp_q.delete();
    tick(5);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_still_idle", 32'(busy), 32'd0);
    b0 = beats_total;
    push_dump();
    pulse_start();
    tick(2);
    check("t6_restart_index", 32'(out_index), 32'd0);
    check("t6_restart_valid", 32'(out_valid), 32'd1);
    wait_done(cyc);
    tick(3);
    check("t6_beats", 32'(beats_total - b0), 32'd32);
    check("t6_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
